// File: rtl/ascii_hex_collector.sv
// Frames CR-terminated lines of up to eight ASCII hex digits into a right-justified uppercase word.
// Latency: one cycle from the terminator/offending strobe to word_valid/word_error; no backpressure, every strobe is consumed.
module ascii_hex_collector #(
    parameter logic [7:0] TERM_CHAR   = 8'h0D,
    parameter logic [7:0] IGNORE_CHAR = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ascii_7,
    output logic [7:0] ascii_6,
    output logic [7:0] ascii_5,
    output logic [7:0] ascii_4,
    output logic [7:0] ascii_3,
    output logic [7:0] ascii_2,
    output logic [7:0] ascii_1,
    output logic [7:0] ascii_0,
    output logic       word_valid,
    output logic       word_error,
    output logic [3:0] digit_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [63:0] ALL_ZERO_CHARS = {8{8'h30}};

    state_t      state_q;
    logic [63:0] buf_q;
    logic [3:0]  cnt_q;
    logic [63:0] out_q;
    logic        word_valid_q;
    logic        word_error_q;

    logic       is_digit_d;
    logic [7:0] digit_d;

    // Lowercase a-f is folded so the downstream decoder only sees uppercase.
    always_comb begin
        is_digit_d = 1'b0;
        digit_d    = rx_data;
        if ((rx_data >= 8'h30 && rx_data <= 8'h39) ||
            (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            is_digit_d = 1'b1;
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_digit_d = 1'b1;
            digit_d    = rx_data - 8'h20;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            buf_q        <= ALL_ZERO_CHARS;
            cnt_q        <= 4'd0;
            out_q        <= ALL_ZERO_CHARS;
            word_valid_q <= 1'b0;
            word_error_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            word_error_q <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    COLLECT: begin
                        if (rx_data == TERM_CHAR) begin
                            if (cnt_q != 4'd0) begin
                                out_q        <= buf_q;
                                word_valid_q <= 1'b1;
                                buf_q        <= ALL_ZERO_CHARS;
                                cnt_q        <= 4'd0;
                            end
                        end else if (rx_data == IGNORE_CHAR) begin
                            state_q <= COLLECT;
                        end else if (is_digit_d && cnt_q < 4'd8) begin
                            buf_q <= {buf_q[55:0], digit_d};
                            cnt_q <= cnt_q + 4'd1;
                        end else begin
                            word_error_q <= 1'b1;
                            state_q      <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        // Stay silent until the line ends, then start clean.
                        if (rx_data == TERM_CHAR) begin
                            state_q <= COLLECT;
                            buf_q   <= ALL_ZERO_CHARS;
                            cnt_q   <= 4'd0;
                        end
                    end
                    default: state_q <= COLLECT;
                endcase
            end
        end
    end

    assign ascii_7     = out_q[63:56];
    assign ascii_6     = out_q[55:48];
    assign ascii_5     = out_q[47:40];
    assign ascii_4     = out_q[39:32];
    assign ascii_3     = out_q[31:24];
    assign ascii_2     = out_q[23:16];
    assign ascii_1     = out_q[15:8];
    assign ascii_0     = out_q[7:0];
    assign word_valid  = word_valid_q;
    assign word_error  = word_error_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_ascii_hex_collector.sv
// Directed bench for ascii_hex_collector: each task drives one scenario and checks against hand-computed words.
module tb_ascii_hex_collector;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ascii_7, ascii_6, ascii_5, ascii_4, ascii_3, ascii_2, ascii_1, ascii_0;
    logic       word_valid;
    logic       word_error;
    logic [3:0] digit_count;

    logic [63:0] ascii_all;
    assign ascii_all = {ascii_7, ascii_6, ascii_5, ascii_4, ascii_3, ascii_2, ascii_1, ascii_0};

    int checks = 0;
    int errors = 0;

    ascii_hex_collector dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ascii_7    (ascii_7),
        .ascii_6    (ascii_6),
        .ascii_5    (ascii_5),
        .ascii_4    (ascii_4),
        .ascii_3    (ascii_3),
        .ascii_2    (ascii_2),
        .ascii_1    (ascii_1),
        .ascii_0    (ascii_0),
        .word_valid (word_valid),
        .word_error (word_error),
        .digit_count(digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobe per byte with an idle cycle after it; pulses are sampled one cycle after the strobe edge.
    int nv, ne, err_idx, stretched, both_high;

    task automatic send_str(input string s);
        nv = 0; ne = 0; err_idx = -1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (word_valid || word_error) stretched++;
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'hxx;
            if (word_valid && word_error) both_high++;
            if (word_valid) nv++;
            if (word_error) begin
                ne++;
                if (err_idx < 0) err_idx = i;
            end
        end
        @(negedge clk);
        if (word_valid || word_error) stretched++;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ascii_all !== {8{8'h30}}) begin
            errors++; $display("FAIL reset_ascii got %h want %h", ascii_all, {8{8'h30}});
        end
        checks++;
        if (word_valid !== 1'b0 || word_error !== 1'b0 || digit_count !== 4'd0) begin
            errors++; $display("FAIL reset_flags got wv=%b we=%b cnt=%0d want 0 0 0", word_valid, word_error, digit_count);
        end
    endtask

    task automatic test_full_word();
        send_str("DEADBEEF\015");
        checks++;
        if (ascii_all !== 64'h4445414442454546) begin
            errors++; $display("FAIL deadbeef_word got %h want %h", ascii_all, 64'h4445414442454546);
        end
        checks++;
        if (nv !== 1 || ne !== 0) begin
            errors++; $display("FAIL deadbeef_pulses got wv=%0d we=%0d want 1 0", nv, ne);
        end
    endtask

    task automatic test_short_and_lowercase();
        send_str("1f\015");
        checks++;
        if (ascii_all !== 64'h3030303030303146 || nv !== 1) begin
            errors++; $display("FAIL short_1f got %h wv=%0d want %h wv=1", ascii_all, nv, 64'h3030303030303146);
        end
        send_str("123");
        checks++;
        if (digit_count !== 4'd3) begin
            errors++; $display("FAIL digit_count got %0d want 3", digit_count);
        end
        send_str("\015c0ffee\015");
        checks++;
        if (ascii_all !== 64'h3030433046464545 || nv !== 2) begin
            errors++; $display("FAIL fold_c0ffee got %h wv=%0d want %h wv=2", ascii_all, nv, 64'h3030433046464545);
        end
    endtask

    task automatic test_overflow();
        send_str("123456789\015");
        checks++;
        if (ne !== 1 || err_idx !== 8 || nv !== 0) begin
            errors++; $display("FAIL overflow_pulse got we=%0d idx=%0d wv=%0d want 1 8 0", ne, err_idx, nv);
        end
        checks++;
        if (ascii_all !== 64'h3030433046464545) begin
            errors++; $display("FAIL overflow_hold got %h want %h", ascii_all, 64'h3030433046464545);
        end
        send_str("7\015");
        checks++;
        if (ascii_all !== 64'h3030303030303037 || nv !== 1) begin
            errors++; $display("FAIL after_overflow got %h wv=%0d want %h wv=1", ascii_all, nv, 64'h3030303030303037);
        end
    endtask

    task automatic test_bad_char();
        send_str("12G4\012\015");
        checks++;
        if (ne !== 1 || err_idx !== 2 || nv !== 0) begin
            errors++; $display("FAIL bad_char_pulse got we=%0d idx=%0d wv=%0d want 1 2 0", ne, err_idx, nv);
        end
        checks++;
        if (ascii_all !== 64'h3030303030303037) begin
            errors++; $display("FAIL bad_char_hold got %h want %h", ascii_all, 64'h3030303030303037);
        end
        send_str("AB\015");
        checks++;
        if (ascii_all !== 64'h3030303030304142 || nv !== 1 || ne !== 0) begin
            errors++; $display("FAIL after_bad got %h wv=%0d we=%0d want %h 1 0", ascii_all, nv, ne, 64'h3030303030304142);
        end
    endtask

    task automatic test_empty_lines();
        send_str("\015\012\012\015");
        checks++;
        if (nv !== 0 || ne !== 0 || ascii_all !== 64'h3030303030304142 || digit_count !== 4'd0) begin
            errors++; $display("FAIL empty_lines got wv=%0d we=%0d %h cnt=%0d want 0 0 %h 0",
                               nv, ne, ascii_all, digit_count, 64'h3030303030304142);
        end
    endtask

    task automatic test_back_to_back();
        string s;
        logic [7:0] first_a0, last_a0;
        int bv, be;
        s = "0A\015\0155\015";
        bv = 0; be = 0; first_a0 = 8'h00; last_a0 = 8'h00;
        for (int i = 0; i <= s.len(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (word_valid && word_error) both_high++;
                if (word_error) be++;
                if (word_valid) begin
                    bv++;
                    if (bv == 1) first_a0 = ascii_0;
                    last_a0 = ascii_0;
                end
            end
            if (i < s.len()) begin
                rx_data  = s[i];
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
        end
        checks++;
        if (bv !== 2 || be !== 0) begin
            errors++; $display("FAIL b2b_pulses got wv=%0d we=%0d want 2 0", bv, be);
        end
        checks++;
        if (first_a0 !== 8'h41 || last_a0 !== 8'h35) begin
            errors++; $display("FAIL b2b_ascii0 got %h %h want 41 35", first_a0, last_a0);
        end
        checks++;
        if (ascii_all !== 64'h3030303030303035) begin
            errors++; $display("FAIL b2b_word got %h want %h", ascii_all, 64'h3030303030303035);
        end
    endtask

    task automatic test_mid_line_reset();
        send_str("ABC");
        checks++;
        if (digit_count !== 4'd3) begin
            errors++; $display("FAIL pre_reset_count got %0d want 3", digit_count);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (digit_count !== 4'd0 || ascii_all !== {8{8'h30}} || word_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got cnt=%0d %h wv=%b want 0 %h 0", digit_count, ascii_all, word_valid, {8{8'h30}});
        end
        @(negedge clk);
        reset = 1'b0;
        send_str("D\015");
        checks++;
        if (ascii_all !== 64'h3030303030303044 || nv !== 1) begin
            errors++; $display("FAIL post_reset_word got %h wv=%0d want %h 1", ascii_all, nv, 64'h3030303030303044);
        end
    endtask

    initial begin
        stretched = 0; both_high = 0;
        test_reset();
        test_full_word();
        test_short_and_lowercase();
        test_overflow();
        test_bad_char();
        test_empty_lines();
        test_back_to_back();
        test_mid_line_reset();
        checks++;
        if (stretched !== 0 || both_high !== 0) begin
            errors++; $display("FAIL pulse_shape got stretched=%0d both=%0d want 0 0", stretched, both_high);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_hex_collector.md
# ascii_hex_collector

Upstream framing stage for `ascii_to_value`. It takes the byte stream from the UART receiver and collects up to eight ASCII hex digits terminated by a carriage return. Each completed word is presented as eight right-justified, zero-padded, uppercase ASCII characters on `ascii_7..ascii_0`, with a one-cycle valid pulse. Malformed lines are discarded and flagged.

## Interface
Parameters:
- `TERM_CHAR`, default 8'h0D, line terminator.
- `IGNORE_CHAR`, default 8'h0A, byte silently dropped in every state (LF).

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received byte. Sampled only when `rx_valid`=1.
- `rx_valid` input 1: one-cycle strobe per received byte. May be high on consecutive cycles.
- `ascii_7`…`ascii_0` output 8 each: held word. `ascii_7` is the most significant digit. Registered.
- `word_valid` output 1: one-cycle pulse; the `ascii_*` outputs were updated on this edge.
- `word_error` output 1: one-cycle pulse when a line is rejected.
- `digit_count` output 4: digits collected so far in the current line, 0..8 (debug).

## Operation
- Internal state:
  - 64-bit shift buffer `buf`, eight bytes.
  - 4-bit counter `cnt`.
  - State machine with two states: COLLECT and DISCARD.
  - Output holding registers `ascii_*`, separate from `buf`.
- Digit classes:
  - 0x30–0x39 and 0x41–0x46: stored unchanged.
  - 0x61–0x66: folded to uppercase by subtracting 0x20. `ascii_to_value` decodes uppercase only.
- COLLECT state, on `rx_valid`:
  - Digit with `cnt`<8: `buf` shifts left one byte, the new byte enters `buf[7:0]`, and `cnt` increments.
  - Digit with `cnt`=8: `word_error` pulses; go to DISCARD.
  - TERM_CHAR with `cnt`=0: ignored. No pulse and no output change.
  - TERM_CHAR with `cnt`≥1: copy `buf` to `ascii_7..ascii_0` and pulse `word_valid`. Reload `buf` with all 0x30 and clear `cnt` to 0.
  - IGNORE_CHAR: no effect.
  - Any other byte: `word_error` pulses; go to DISCARD.
- DISCARD state, on `rx_valid`:
  - All bytes other than TERM_CHAR are ignored, with no further error pulses.
  - TERM_CHAR: go to COLLECT, reload `buf` with 0x30 and clear `cnt`. No `word_valid`.
- Zero padding falls out of the design: `buf` starts every line as eight 0x30 bytes, so short lines are right-justified.
  - Example: "1f" followed by CR produces 0x30 ×6, then 0x31, 0x46.
- `ascii_*` hold their value until the next successful word. A rejected line never alters them.
- When `rx_valid`=0, `rx_data` is don't-care.

## Timing
- Reset values:
  - `ascii_*` = 8'h30.
  - `word_valid` = 0, `word_error` = 0, `digit_count` = 0.
  - `buf` = all 8'h30.
  - State = COLLECT.
- Latency:
  - `word_valid` and the new `ascii_*` appear on the first rising edge at which `rx_valid` is high with TERM_CHAR.
  - They are visible in the following cycle, so latency is one cycle from the terminator strobe.
  - `word_error` has the same one-cycle latency relative to the offending byte.
- `word_valid` and `word_error` are mutually exclusive and are never high for more than one cycle per event.
- Back-to-back strobes: a CR followed immediately by a digit must work. The digit on the next cycle enters the freshly reloaded `buf` with `cnt`=0 → 1.
- `digit_count` reflects `cnt` registered, updated on the same edge as `buf`.
- Reset asserted mid-line:
  - All state returns to reset values immediately and asynchronously.
  - The partial line is lost and no pulse is generated.
  - The first byte after reset deasserts begins a new line.
- There is no inter-character timeout. An unterminated line waits indefinitely.

## Test plan
- Reset, then "DEADBEEF" CR → `ascii_7..0` = 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46; one `word_valid` pulse, one cycle after the CR strobe.
- "1f" CR → `ascii_*` = 0x30 ×6, then 0x31, 0x46. `ascii_to_value` downstream reads 32'h0000001F.
- "123456789" CR → `word_error` pulses on the ninth digit. No `word_valid`. `ascii_*` keep their prior word. A following "7" CR yields 0x30 ×7, then 0x37.
- "12G4" LF CR → `word_error` pulses on 'G' only. The LF and CR produce no pulse. The next line "AB" CR is accepted.
- CR alone, and LF alone → no pulses and no output change. `rx_valid` high on every cycle for "0A" CR CR "5" CR → two `word_valid` pulses, the second with `ascii_0`=0x35.
- Assert `reset` after "ABC" → `digit_count`=0 and `ascii_*`=0x30 immediately. After release, "D" CR gives `ascii_0`=0x44 and 0x30 elsewhere.
